// File: rtl/uart_tx_sched.sv
// Shares one MiniUART transmitter between two byte producers: programs the baud
// divisors once after reset, then arbitrates, polls LSR for idle, writes, and waits.
module uart_tx_sched #(
    parameter logic [15:0] DIVR_VAL   = 16'd2604,
    parameter logic [15:0] DIVT_VAL   = 16'd2604,
    parameter int          GAP_CYCLES = 4,
    parameter logic [2:0]  OFF_DATA   = 3'd0,
    parameter logic [2:0]  OFF_LSR    = 3'd1,
    parameter logic [2:0]  OFF_DIVR   = 3'd2,
    parameter logic [2:0]  OFF_DIVT   = 3'd3,
    parameter int          TS_BIT     = 5
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [4:2]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        cfg_done,
    output logic        busy
);

    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CFG_R = 3'd0,
        S_CFG_T = 3'd1,
        S_IDLE  = 3'd2,
        S_POLL  = 3'd3,
        S_WRITE = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            cfg_done_q, cfg_done_d;
    logic            last_q, last_d;       // 1 = req1 served most recently
    logic            grant_q, grant_d;     // 1 = req1 holds the current grant
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            wr_ack_s;
    logic            grant1_s;
    logic            dat_i_unused_s;

    assign dat_i_unused_s = ^DAT_I;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= S_CFG_R;
            cfg_done_q <= 1'b0;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_byte_q  <= tx_byte_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state, arbitration and gap counting.
    always_comb begin
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
        last_d     = last_q;
        grant_d    = grant_q;
        tx_byte_d  = tx_byte_q;
        gap_cnt_d  = gap_cnt_q;
        wr_ack_s   = 1'b0;
        // On a tie the producer not served last wins.
        grant1_s   = req1_valid && (!req0_valid || !last_q);
        case (state_q)
            S_CFG_R: begin
                if (ACK_I) state_d = S_CFG_T;
                else       state_d = S_CFG_R;
            end
            S_CFG_T: begin
                if (ACK_I) begin
                    state_d    = S_IDLE;
                    cfg_done_d = 1'b1;
                end else begin
                    state_d    = S_CFG_T;
                end
            end
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d   = grant1_s;
                    tx_byte_d = grant1_s ? req1_data : req0_data;
                    state_d   = S_POLL;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_POLL: begin
                if (ACK_I && DAT_I[TS_BIT]) state_d = S_WRITE;
                else                        state_d = S_POLL;
            end
            S_WRITE: begin
                if (ACK_I) begin
                    wr_ack_s  = 1'b1;
                    last_d    = grant_q;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = S_GAP;
                end else begin
                    state_d   = S_WRITE;
                end
            end
            S_GAP: begin
                // Lets the UART's ts drop after the load before the next poll.
                if (gap_cnt_q == '0) begin
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = S_CFG_R;
        endcase
    end

    // Moore bus decode; ready pulses follow the WRITE acknowledge directly.
    always_comb begin
        STB_O = 1'b0;
        WE_O  = 1'b0;
        ADD_O = 3'd0;
        DAT_O = 32'h0000_0000;
        case (state_q)
            S_CFG_R: begin
                STB_O = 1'b1;
                WE_O  = 1'b1;
                ADD_O = OFF_DIVR;
                DAT_O = {16'h0000, DIVR_VAL};
            end
            S_CFG_T: begin
                STB_O = 1'b1;
                WE_O  = 1'b1;
                ADD_O = OFF_DIVT;
                DAT_O = {16'h0000, DIVT_VAL};
            end
            S_POLL: begin
                STB_O = 1'b1;
                ADD_O = OFF_LSR;
            end
            S_WRITE: begin
                STB_O = 1'b1;
                WE_O  = 1'b1;
                ADD_O = OFF_DATA;
                DAT_O = {24'h000000, tx_byte_q};
            end
            default: begin
                STB_O = 1'b0;
            end
        endcase
        req0_ready = wr_ack_s && !grant_q && !RST_I;
        req1_ready = wr_ack_s &&  grant_q && !RST_I;
    end

    assign cfg_done = cfg_done_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of per-cycle vectors plus hand-written
// sequences for wait states, ts polling, round-robin and mid-transfer reset.
module tb_uart_tx_sched;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [4:2]  ADD_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I = 32'h0000_0020;
    logic        STB_O, WE_O, ACK_I;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
    logic        req0_ready, req1_ready, cfg_done, busy;
    logic        ack_en = 1'b1;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] DIV = 32'h0000_0A2C;

    // Zero-wait slave that can withhold its acknowledge.
    assign ACK_I = STB_O & ack_en;

    always #5 CLK_I = ~CLK_I;

    uart_tx_sched dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADD_O(ADD_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
        .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .cfg_done(cfg_done), .busy(busy)
    );

    typedef struct {
        logic        rst, v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        ack;
        logic [31:0] lsr;
        logic        chk;
        logic        stb, we;
        logic [2:0]  add;
        logic [31:0] dat;
        logic        r0, r1, cfg, bsy;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic stb, input logic we,
                           input logic [2:0] add, input logic [31:0] dat);
        chk({tag, " STB_O"}, {31'd0, STB_O}, {31'd0, stb});
        chk({tag, " WE_O"},  {31'd0, WE_O},  {31'd0, we});
        chk({tag, " ADD_O"}, {29'd0, ADD_O}, {29'd0, add});
        chk({tag, " DAT_O"}, DAT_O, dat);
    endtask

    task automatic gap_to_idle(input string tag);
        // Called in the first GAP cycle; three more GAP cycles, then IDLE.
        for (int g = 0; g < 4; g++) tick();
        chk({tag, " idle after gap"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_and_cfg(input string tag);
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        #1;
        chk_bus({tag, " cfg_r"}, 1'b1, 1'b1, 3'd2, DIV);
        chk({tag, " cfg_done low"}, {31'd0, cfg_done}, 32'd0);
        chk({tag, " busy cfg"}, {31'd0, busy}, 32'd1);
        tick();
        chk_bus({tag, " cfg_t"}, 1'b1, 1'b1, 3'd3, DIV);
        tick();
        chk({tag, " cfg_done high"}, {31'd0, cfg_done}, 32'd1);
        chk({tag, " busy idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          rst   v0    d0     v1    d1     ack   lsr           chk   stb   we    add   dat           r0    r1    cfg   busy
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b1, 1'b1, 3'd2, DIV,          1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b1, 1'b1, 3'd3, DIV,          1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b0, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b1, 1'b0, 3'd1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b1, 1'b1, 3'd0, 32'h00000041, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 6; i < 10; i++)
            vecs[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b0, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'h00000020, 1'b1, 1'b0, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset, configuration and one byte from req0 with ts already set.
        for (int i = 0; i < 11; i++) begin
            RST_I      = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            ack_en     = vecs[i].ack;
            DAT_I      = vecs[i].lsr;
            #1;
            if (vecs[i].chk) begin
                chk_bus($sformatf("vec%0d", i), vecs[i].stb, vecs[i].we, vecs[i].add, vecs[i].dat);
                chk($sformatf("vec%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
                chk($sformatf("vec%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
                chk($sformatf("vec%0d cfg_done", i),   {31'd0, cfg_done},   {31'd0, vecs[i].cfg});
                chk($sformatf("vec%0d busy", i),       {31'd0, busy},       {31'd0, vecs[i].bsy});
            end
            tick();
        end

        // ts=0 for three polls, then idle: four POLL cycles before WRITE.
        DAT_I = 32'h0000_0000;
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        #1;
        chk("ts idle", {31'd0, busy}, 32'd0);
        tick();
        for (int p = 0; p < 4; p++) begin
            if (p == 3) DAT_I = 32'h0000_0020;
            #1;
            chk_bus($sformatf("ts poll%0d", p), 1'b1, 1'b0, 3'd1, 32'h0);
            chk($sformatf("ts poll%0d ready", p), {31'd0, req0_ready}, 32'd0);
            tick();
        end
        chk_bus("ts write", 1'b1, 1'b1, 3'd0, 32'h0000_0055);
        chk("ts write ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("ts gap ready", {31'd0, req0_ready}, 32'd0);
        gap_to_idle("ts");

        // Round-robin after fresh reset: req0 wins first tie, then alternate.
        reset_and_cfg("rr");
        DAT_I = 32'h0000_0020;
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d idle", k), {31'd0, busy}, 32'd0);
            tick();
            chk($sformatf("rr%0d poll add", k), {29'd0, ADD_O}, 32'd1);
            tick();
            chk($sformatf("rr%0d dat", k), DAT_O, (k % 2 == 0) ? 32'h11 : 32'h22);
            chk($sformatf("rr%0d req0_ready", k), {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d req1_ready", k), {31'd0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk($sformatf("rr%0d pulse end", k), {30'd0, req1_ready, req0_ready}, 32'd0);
            gap_to_idle($sformatf("rr%0d", k));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // WRITE acknowledge withheld for two cycles.
        tick();
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        #1;
        tick();
        tick();
        ack_en = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            chk_bus($sformatf("hold%0d", w), 1'b1, 1'b1, 3'd0, 32'h0000_00A5);
            chk($sformatf("hold%0d ready", w), {31'd0, req0_ready}, 32'd0);
            tick();
        end
        ack_en = 1'b1;
        #1;
        chk_bus("hold ack", 1'b1, 1'b1, 3'd0, 32'h0000_00A5);
        chk("hold ack ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("hold gap ready", {31'd0, req0_ready}, 32'd0);
        gap_to_idle("hold");

        // Reset mid-POLL with req1 pending: reconfigure, then serve req1.
        DAT_I = 32'h0000_0000;
        req1_valid = 1'b1;
        req1_data  = 8'h77;
        #1;
        tick();
        chk("rst poll add", {29'd0, ADD_O}, 32'd1);
        tick();
        RST_I = 1'b1;
        #1;
        chk("rst no ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        RST_I = 1'b0;
        #1;
        chk_bus("rst cfg_r", 1'b1, 1'b1, 3'd2, DIV);
        chk("rst cfg_done low", {31'd0, cfg_done}, 32'd0);
        tick();
        chk_bus("rst cfg_t", 1'b1, 1'b1, 3'd3, DIV);
        tick();
        chk("rst cfg_done high", {31'd0, cfg_done}, 32'd1);
        DAT_I = 32'h0000_0020;
        tick();
        chk("rst poll2 add", {29'd0, ADD_O}, 32'd1);
        tick();
        chk_bus("rst write", 1'b1, 1'b1, 3'd0, 32'h0000_0077);
        chk("rst req1_ready", {31'd0, req1_ready}, 32'd1);
        chk("rst req0_ready", {31'd0, req0_ready}, 32'd0);
        tick();
        req1_valid = 1'b0;
        #1;
        gap_to_idle("rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one MiniUART transmitter between two byte producers. Sits between the producers and the MiniUART WISHBONE slave port. After reset it programs the RX/TX baud divisors once. From then on it arbitrates round-robin between the producers, polls the line status register until the transmitter is idle, writes the granted byte, and enforces a settle gap before the next poll.

## Interface
- DIVR_VAL, default 16'd2604: value written to the DIVR register at configuration.
- DIVT_VAL, default 16'd2604: value written to the DIVT register at configuration.
- GAP_CYCLES, default 4: idle cycles after a DATA write before the next LSR poll (≥1).
- OFF_DATA / OFF_LSR / OFF_DIVR / OFF_DIVT, default 3'd0 / 3'd1 / 3'd2 / 3'd3: register offsets on ADD_O.
- TS_BIT, default 5: bit of the LSR read data that is 1 while the transmitter is idle.

Ports:
- CLK_I  in  1  clock; the only clock.
- RST_I  in  1  reset; synchronous, active-high.
- ADD_O  out  [4:2]  MiniUART register offset.
- DAT_O  out  32  write data.
- DAT_I  in  32  read data.
- STB_O  out  1  strobe.
- WE_O  out  1  write enable.
- ACK_I  in  1  acknowledge; may arrive in the same cycle as STB_O.
- req0_valid, req1_valid  in  1  producer has a byte pending.
- req0_data, req1_data  in  8  pending byte.
- req0_ready, req1_ready  out  1  one-cycle pulse: byte written to the UART.
- cfg_done  out  1  divisor configuration complete.
- busy  out  1  high in every state except IDLE.

## Operation
- States: CFG_R, CFG_T, IDLE, POLL, WRITE, GAP.
- Outputs are Moore-decoded from the state, except the ready pulses.

CFG_R
- Drives STB_O=1, WE_O=1, ADD_O=OFF_DIVR, DAT_O={16'b0,DIVR_VAL}.
- On ACK_I, go to CFG_T.

CFG_T
- Same as CFG_R, with ADD_O=OFF_DIVT and DIVT_VAL.
- On ACK_I, go to IDLE and set cfg_done.

IDLE
- STB_O=0.
- If any valid is high: grant a requester, latch its data into tx_byte, go to POLL.
- Arbitration: with one requester valid, grant that one. With both valid, grant the one not served last. The last-served flag resets to 1, so req0 wins the first tie.

POLL
- Drives STB_O=1, WE_O=0, ADD_O=OFF_LSR.
- On ACK_I with DAT_I[TS_BIT]=1, go to WRITE.
- On ACK_I with DAT_I[TS_BIT]=0, stay in POLL and re-poll every cycle; no timeout.

WRITE
- Drives STB_O=1, WE_O=1, ADD_O=OFF_DATA, DAT_O={24'b0,tx_byte}.
- On ACK_I: assert reqN_ready for the granted N in that same cycle (combinational from state&ACK_I), update last-served, load the gap counter with GAP_CYCLES-1, go to GAP.

GAP
- STB_O=0. Decrement the counter each cycle; at 0, go to IDLE.
- Purpose: MiniUART's load pulse and its ts fall occur after the write, so an immediate re-poll would read a stale ts=1.

Requester and bus rules:
- A requester holds valid and data stable until its ready pulse. Data is sampled once, at IDLE→POLL.
- Deasserting valid before ready is illegal; the latched byte is still sent.
- A bus state without ACK_I holds its outputs unchanged.

## Timing
Reset values (first cycle after RST_I sampled high):
- State=CFG_R, cfg_done=0, ready pulses=0, last-served=1, tx_byte=0, gap counter=0.
- Outputs in CFG_R: STB_O=1, WE_O=1, ADD_O=OFF_DIVR, DAT_O={16'b0,DIVR_VAL}, busy=1.

Latency with ACK_I=STB_O:
- Configuration takes 2 cycles; cfg_done rises on cycle 3.
- Byte with ts=1 already: valid seen in IDLE (cycle 0), POLL (1), WRITE with ready (2), GAP for cycles 3…2+GAP_CYCLES, IDLE at 3+GAP_CYCLES.
- Back-to-back bytes are therefore spaced ≥3+GAP_CYCLES cycles apart, plus the poll cycles spent while ts=0.

Boundary conditions:
- Reset in any state aborts with no ready pulse and restarts at CFG_R; configuration repeats. A producer still holding valid is served after reconfiguration.
- Valid arriving during GAP or POLL is not sampled until IDLE.
- Both valid in IDLE: exactly one grant per IDLE visit.

## Test plan
- Reset with default params, ACK_I=STB_O → writes at ADD 2 then 3, both with data 2604; cfg_done=1 on cycle 3; busy=0 on cycle 3.
- req0_valid, data 8'h41, LSR returns 32'h20 → one poll, DATA write with DAT_O=32'h41, req0_ready high exactly 1 cycle, then GAP for 4 cycles.
- LSR returns 32'h00 for 3 polls then 32'h20 → 4 POLL cycles, then WRITE; no ready before WRITE.
- Both requesters held valid (8'h11 and 8'h22) for 4 bytes → grant order req0, req1, req0, req1; DAT_O values 11, 22, 11, 22; each ready pulse single-cycle.
- ACK_I withheld 2 cycles in WRITE → STB/WE/ADD/DAT_O stable; ready only in the ACK cycle.
- RST_I asserted mid-POLL with req1 valid → no ready pulse, CFG_R/CFG_T repeated, then req1's byte is sent.
